// File: rtl/fifo_frame_pkg.sv
// Shared types and helpers for the FIFO frame reader.
package fifo_frame_pkg;

  localparam int unsigned MAX_FRAME_LEN = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Map any requested length onto the legal 1..MAX_FRAME_LEN range.
  function automatic int unsigned clamp_len(input int unsigned len);
    int unsigned res;
    if (len == 0) begin
      res = 1;
    end else if (len > MAX_FRAME_LEN) begin
      res = MAX_FRAME_LEN;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_frame_reader_out_reg.sv
// Single-entry output register: loads on pop, holds while stalled, empties on accept.
module frame_out_reg #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_sof,
  output logic                  o_eof
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sof;
  logic                  r_eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_pop) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_sof   <= i_sof;
      r_eof   <= i_eof;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains a show-ahead FIFO into fixed-length frames with sof/eof markers,
// an optional inter-frame gap, and frame/underrun status counters.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  rd_en,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  underrun_cnt
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_first;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_stop_req;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic [CNT_WIDTH-1:0]  r_underrun_cnt;

  logic                  w_pop;
  logic                  w_eof_acc;
  logic                  w_frame_done;
  logic                  w_stop_any;
  logic                  w_gap_done;
  logic                  w_load;
  logic                  w_underrun;
  logic [LEN_WIDTH-1:0]  w_len;

  assign w_len        = LEN_WIDTH'(clamp_len(32'(frame_len)));
  assign w_pop        = rd_en && rd_vld;
  assign w_eof_acc    = out_valid && out_ready && out_eof;
  assign w_frame_done = (r_state == ST_STREAM) && w_eof_acc;
  assign w_stop_any   = r_stop_req || stop;
  assign w_gap_done   = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
  assign w_load       = ((r_state == ST_IDLE) && start) || w_gap_done ||
                        (w_frame_done && !w_stop_any && (GAP_CYCLES == 0));
  assign w_underrun   = (r_state == ST_STREAM) && (r_remain != '0) && !out_valid && !rd_vld;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_frame_done) begin
          if (w_stop_any)           w_state_nxt = ST_IDLE;
          else if (GAP_CYCLES != 0) w_state_nxt = ST_GAP;
          else                      w_state_nxt = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (w_gap_done) w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The pop request is suppressed during reset so the FIFO is never drained then.
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    if (!rd_rst) begin
      rd_en = (r_state == ST_STREAM) && rd_vld && (r_remain != '0) &&
              (!out_valid || out_ready);
    end
    busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_remain       <= '0;
      r_first        <= 1'b0;
      r_gap_cnt      <= '0;
      r_stop_req     <= 1'b0;
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_load) begin
        r_remain <= w_len;
        r_first  <= 1'b1;
      end else if (w_pop) begin
        r_remain <= r_remain - 1'b1;
        r_first  <= 1'b0;
      end
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (w_frame_done && w_stop_any) begin
        r_stop_req <= 1'b0;
      end else if (stop && (r_state != ST_IDLE)) begin
        r_stop_req <= 1'b1;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_underrun && (r_underrun_cnt != '1)) begin
        r_underrun_cnt <= r_underrun_cnt + 1'b1;
      end
    end
  end

  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;

  frame_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .i_pop  (w_pop),
    .i_data (rd_data),
    .i_sof  (r_first),
    .i_eof  (r_remain == LEN_WIDTH'(1)),
    .i_ready(out_ready),
    .o_data (out_data),
    .o_valid(out_valid),
    .o_sof  (out_sof),
    .o_eof  (out_eof)
  );

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader with a show-ahead FIFO model.
module tb_fifo_frame_reader;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        e;
  } beat_t;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] frame_len = 11'd0;
  logic        rd_en;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  beat_t exp_q[$];

  logic [15:0] src [0:4095];
  int   src_wr = 0;
  int   src_rd = 0;
  logic pop_pend = 1'b0;
  logic flush = 1'b0;
  logic bp_mode = 1'b0;

  fifo_frame_reader dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .start       (start),
    .stop        (stop),
    .frame_len   (frame_len),
    .rd_en       (rd_en),
    .rd_vld      (rd_vld),
    .rd_data     (rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // Show-ahead FIFO model: contents are src[src_rd .. src_wr-1].
  assign rd_vld  = (src_rd < src_wr);
  assign rd_data = src[src_rd[11:0]];
  always @(negedge rd_clk) pop_pend = rd_en && rd_vld;
  always @(posedge rd_clk) begin
    if (flush) src_rd <= src_wr;
    else if (pop_pend) src_rd <= src_rd + 1;
  end

  always @(posedge rd_clk) begin
    #2;
    out_ready = bp_mode ? !out_ready : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks hold/pop rules.
  logic        prev_stall = 1'b0;
  logic [17:0] prev_beat = '0;
  always @(negedge rd_clk) begin
    beat_t b;
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_beat", 32'({out_data, out_sof, out_eof}), 32'(prev_beat));
      end
      if (rd_en) begin
        chk("rd_en_room", 32'(!out_valid || out_ready), 32'd1);
        chk("rd_en_vld", 32'(rd_vld), 32'd1);
      end
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(b.d));
          chk("beat_sof_eof", 32'({out_sof, out_eof}), 32'({b.s, b.e}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_sof, out_eof};
    end
  end

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      src[src_wr[11:0]] = 16'(base + i);
      src_wr++;
    end
  endtask

  task automatic expect_frames(input int base, input int len_req, input int nfr);
    int l;
    beat_t b;
    l = (len_req == 0) ? 1 : ((len_req > 1024) ? 1024 : len_req);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < l; i++) begin
        b.d = 16'(base + f * l + i);
        b.s = (i == 0);
        b.e = (i == l - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    flush = 1'b1;
    repeat (2) @(posedge rd_clk);
    #2;
    rd_rst = 1'b0;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start(input int len);
    frame_len = 11'(len);
    start = 1'b1;
    @(posedge rd_clk);
    #2;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge rd_clk);
    #2;
    stop = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sof_eof"}, 32'({out_sof, out_eof}), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_rd_en_busy"}, 32'({rd_en, busy}), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    @(negedge rd_clk);
    while ((busy || out_valid || exp_q.size() != 0) && g < budget) begin
      @(negedge rd_clk);
      g++;
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int g;
    int n0;
    int idx0;

    // Reset state
    do_reset();
    @(negedge rd_clk);
    check_zero_outputs("reset");

    // Basic: two 8-sample frames separated by the gap
    do_reset();
    load(0, 16);
    expect_frames(0, 8, 2);
    pulse_start(8);
    g = 0;
    while (frame_cnt != 16'd1 && g < 200) begin
      @(negedge rd_clk);
      g++;
    end
    chk("basic_first_frame", 32'(frame_cnt), 32'd1);
    g = 0;
    stop = 1'b1;
    while (!rd_en && g < 50) begin
      g++;
      @(negedge rd_clk);
      stop = 1'b0;
    end
    stop = 1'b0;
    chk("basic_gap_cycles", 32'(g), 32'd4);
    wait_idle(200);
    chk("basic_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("basic_underrun", 32'(underrun_cnt), 32'd0);

    // Backpressure: out_ready alternates every cycle
    do_reset();
    load(16'h100, 8);
    expect_frames(16'h100, 8, 1);
    bp_mode = 1'b1;
    pulse_start(8);
    pulse_stop();
    wait_idle(200);
    bp_mode = 1'b0;
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("bp_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: three words, then three more arriving late
    do_reset();
    load(16'h200, 3);
    expect_frames(16'h200, 6, 1);
    pulse_start(6);
    pulse_stop();
    repeat (8) @(posedge rd_clk);
    #2;
    load(16'h203, 3);
    wait_idle(200);
    chk("ur_underrun", 32'(underrun_cnt), 32'd5);
    chk("ur_frame_cnt", 32'(frame_cnt), 32'd1);

    // Stop mid-frame: frame completes, then no further pops
    do_reset();
    load(16'h300, 12);
    expect_frames(16'h300, 8, 1);
    n0 = n_acc;
    pulse_start(8);
    g = 0;
    while ((n_acc - n0) < 2 && g < 100) begin
      @(posedge rd_clk);
      #2;
      g++;
    end
    pulse_stop();
    wait_idle(200);
    chk("stop_frame_cnt", 32'(frame_cnt), 32'd1);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (rd_en || busy) g++;
    end
    chk("stop_idle_rd_en", 32'(g), 32'd0);
    chk("stop_fifo_left", 32'(src_wr - src_rd), 32'd4);

    // frame_len=0 behaves as single-sample frames
    do_reset();
    load(16'h400, 3);
    expect_frames(16'h400, 0, 3);
    pulse_start(0);
    g = 0;
    while (frame_cnt != 16'd2 && g < 100) begin
      @(posedge rd_clk);
      #2;
      g++;
    end
    pulse_stop();
    wait_idle(200);
    chk("len0_frame_cnt", 32'(frame_cnt), 32'd3);

    // Oversized length clamps to 1024
    do_reset();
    load(16'h1000, 1024);
    expect_frames(16'h1000, 2000, 1);
    pulse_start(2000);
    pulse_stop();
    wait_idle(3000);
    chk("len2000_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("len2000_fifo_left", 32'(src_wr - src_rd), 32'd0);

    // Reset asserted while the 4th sample is on the output
    do_reset();
    load(16'h500, 16);
    expect_frames(16'h500, 8, 1);
    idx0 = src_rd;
    n0 = n_acc;
    pulse_start(8);
    g = 0;
    while ((n_acc - n0) < 3 && g < 100) begin
      @(posedge rd_clk);
      #2;
      g++;
    end
    chk("rst_mid_sample", 32'({out_valid, out_data}), 32'h1_0503);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("rst_cycle_rd_en", 32'(rd_en), 32'd0);
    @(posedge rd_clk);
    #2;
    rd_rst = 1'b0;
    @(negedge rd_clk);
    check_zero_outputs("rst_mid");
    chk("rst_mid_pops", 32'(src_rd - idx0), 32'd4);
    exp_q.delete();
    expect_frames(16'h504, 8, 1);
    @(posedge rd_clk);
    #2;
    pulse_start(8);
    pulse_stop();
    wait_idle(200);
    chk("rst_restart_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
